// File: rtl/gru_seq_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : gru_seq_driver
//  Description : Sequences a 2-unit fixed-point GRU cell over a time series.
//                Accepts x_t on a valid/ready stream, holds x_t and h_{t-1}
//                on the cell inputs for the cell latency, captures cell_y
//                as the new hidden state and emits it on an output stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module gru_seq_driver #(
   parameter int INT_WIDTH    = 8,
   parameter int FRAC_WIDTH   = 8,
   parameter int WIDTH        = INT_WIDTH + FRAC_WIDTH + 1,
   parameter int CELL_LATENCY = 1,
   parameter int LEN_W        = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             abort,
   input  logic [LEN_W-1:0] seq_len,
   input  logic [WIDTH-1:0] h_init_0,
   input  logic [WIDTH-1:0] h_init_1,
   output logic             busy,
   output logic             done,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_x_0,
   input  logic [WIDTH-1:0] in_x_1,
   output logic [WIDTH-1:0] cell_x_0_0,
   output logic [WIDTH-1:0] cell_x_0_1,
   output logic [WIDTH-1:0] cell_h_0_0,
   output logic [WIDTH-1:0] cell_h_0_1,
   input  logic [WIDTH-1:0] cell_y_0_0,
   input  logic [WIDTH-1:0] cell_y_0_1,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_h_0,
   output logic [WIDTH-1:0] out_h_1,
   output logic             out_last
);

   // Latency counter only has to reach CELL_LATENCY.
   localparam int LCNT_W = (CELL_LATENCY < 2) ? 1 : $clog2(CELL_LATENCY + 1);
   localparam logic [LCNT_W-1:0] C_LCNT_LAST = LCNT_W'(CELL_LATENCY);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT_X  = 2'd1,
      S_COMPUTE = 2'd2,
      S_OUTPUT  = 2'd3
   } state_t;

   state_t            state_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  step_q;
   logic [LCNT_W-1:0] lcnt_q;
   logic [WIDTH-1:0]  x0_q, x1_q;
   logic [WIDTH-1:0]  h0_q, h1_q;
   logic              busy_q, done_q, in_ready_q, out_valid_q, out_last_q;

   // Sequencer: state, counters, data registers and registered handshake flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         step_q      <= '0;
         lcnt_q      <= '0;
         x0_q        <= '0;
         x1_q        <= '0;
         h0_q        <= '0;
         h1_q        <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // abort in IDLE masks a simultaneous start
               if (start && !abort) begin
                  len_q  <= seq_len;
                  h0_q   <= h_init_0;
                  h1_q   <= h_init_1;
                  step_q <= '0;
                  if (seq_len == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     state_q    <= S_WAIT_X;
                     busy_q     <= 1'b1;
                     in_ready_q <= 1'b1;
                  end
               end
            end
            S_WAIT_X: begin
               if (abort) begin
                  state_q    <= S_IDLE;
                  busy_q     <= 1'b0;
                  in_ready_q <= 1'b0;
               end else if (in_valid) begin
                  x0_q       <= in_x_0;
                  x1_q       <= in_x_1;
                  lcnt_q     <= '0;
                  state_q    <= S_COMPUTE;
                  in_ready_q <= 1'b0;
               end
            end
            S_COMPUTE: begin
               if (abort) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else if (lcnt_q == C_LCNT_LAST) begin
                  h0_q        <= cell_y_0_0;
                  h1_q        <= cell_y_0_1;
                  state_q     <= S_OUTPUT;
                  out_valid_q <= 1'b1;
                  out_last_q  <= (step_q == len_q - LEN_W'(1));
               end else begin
                  lcnt_q <= lcnt_q + LCNT_W'(1);
               end
            end
            S_OUTPUT: begin
               if (abort) begin
                  state_q     <= S_IDLE;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
               end else if (out_ready) begin
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  if (out_last_q) begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     step_q     <= step_q + LEN_W'(1);
                     state_q    <= S_WAIT_X;
                     in_ready_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q     <= S_IDLE;
               busy_q      <= 1'b0;
               in_ready_q  <= 1'b0;
               out_valid_q <= 1'b0;
               out_last_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign out_last   = out_last_q;
   assign cell_x_0_0 = x0_q;
   assign cell_x_0_1 = x1_q;
   assign cell_h_0_0 = h0_q;
   assign cell_h_0_1 = h1_q;
   assign out_h_0    = h0_q;
   assign out_h_1    = h1_q;

endmodule
`default_nettype wire

// File: tb/tb_gru_seq_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_gru_seq_driver
//  Description : Self-checking bench for gru_seq_driver. Two instances with
//                cell latency 1 and 3, each closed around a saturating y=x+h
//                cell stub; results are compared with a sequence-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gru_seq_driver;
   localparam int W  = 17;
   localparam int LW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n, start, abort, in_valid, out_ready, sel;
   logic [LW-1:0] seq_len;
   logic [W-1:0]  h_init_0, h_init_1, in_x_0, in_x_1;

   // instance A: CELL_LATENCY=1, instance B: CELL_LATENCY=3
   logic         a_busy, a_done, a_ir, a_ov, a_ol;
   logic [W-1:0] a_cx0, a_cx1, a_ch0, a_ch1, a_cy0, a_cy1, a_oh0, a_oh1;
   logic         b_busy, b_done, b_ir, b_ov, b_ol;
   logic [W-1:0] b_cx0, b_cx1, b_ch0, b_ch1, b_cy0, b_cy1, b_oh0, b_oh1;

   logic a_start, a_abort, a_iv, a_or, b_start, b_abort, b_iv, b_or;
   assign a_start = start & ~sel;     assign b_start = start & sel;
   assign a_abort = abort & ~sel;     assign b_abort = abort & sel;
   assign a_iv    = in_valid & ~sel;  assign b_iv    = in_valid & sel;
   assign a_or    = out_ready & ~sel; assign b_or    = out_ready & sel;

   gru_seq_driver #(.CELL_LATENCY(1)) u_a (
      .clk(clk), .reset_n(reset_n), .start(a_start), .abort(a_abort),
      .seq_len(seq_len), .h_init_0(h_init_0), .h_init_1(h_init_1),
      .busy(a_busy), .done(a_done), .in_valid(a_iv), .in_ready(a_ir),
      .in_x_0(in_x_0), .in_x_1(in_x_1),
      .cell_x_0_0(a_cx0), .cell_x_0_1(a_cx1), .cell_h_0_0(a_ch0), .cell_h_0_1(a_ch1),
      .cell_y_0_0(a_cy0), .cell_y_0_1(a_cy1),
      .out_valid(a_ov), .out_ready(a_or), .out_h_0(a_oh0), .out_h_1(a_oh1), .out_last(a_ol));

   gru_seq_driver #(.CELL_LATENCY(3)) u_b (
      .clk(clk), .reset_n(reset_n), .start(b_start), .abort(b_abort),
      .seq_len(seq_len), .h_init_0(h_init_0), .h_init_1(h_init_1),
      .busy(b_busy), .done(b_done), .in_valid(b_iv), .in_ready(b_ir),
      .in_x_0(in_x_0), .in_x_1(in_x_1),
      .cell_x_0_0(b_cx0), .cell_x_0_1(b_cx1), .cell_h_0_0(b_ch0), .cell_h_0_1(b_ch1),
      .cell_y_0_0(b_cy0), .cell_y_0_1(b_cy1),
      .out_valid(b_ov), .out_ready(b_or), .out_h_0(b_oh0), .out_h_1(b_oh1), .out_last(b_ol));

   // Saturating signed add: reference for both the cell stub and the model.
   function automatic logic [W-1:0] sat(input logic [W-1:0] a, input logic [W-1:0] b);
      int s;
      s = int'($signed(a)) + int'($signed(b));
      if (s > (1 << (W-1)) - 1) s = (1 << (W-1)) - 1;
      else if (s < -(1 << (W-1))) s = -(1 << (W-1));
      return W'(s);
   endfunction

   // Cell stubs: one register stage for A, three for B.
   logic [W-1:0] b_p0 [3];
   logic [W-1:0] b_p1 [3];
   always @(posedge clk) begin
      a_cy0   <= sat(a_cx0, a_ch0);
      a_cy1   <= sat(a_cx1, a_ch1);
      b_p0[0] <= sat(b_cx0, b_ch0);
      b_p1[0] <= sat(b_cx1, b_ch1);
      b_p0[1] <= b_p0[0];  b_p1[1] <= b_p1[0];
      b_p0[2] <= b_p0[1];  b_p1[2] <= b_p1[1];
   end
   assign b_cy0 = b_p0[2];
   assign b_cy1 = b_p1[2];

   // Observed view of the selected instance
   logic         busy, done, in_ready, out_valid, out_last;
   logic [W-1:0] cell_x_0, cell_h_0, cell_h_1, out_h_0, out_h_1;
   assign busy      = sel ? b_busy : a_busy;
   assign done      = sel ? b_done : a_done;
   assign in_ready  = sel ? b_ir   : a_ir;
   assign out_valid = sel ? b_ov   : a_ov;
   assign out_last  = sel ? b_ol   : a_ol;
   assign cell_x_0  = sel ? b_cx0  : a_cx0;
   assign cell_h_0  = sel ? b_ch0  : a_ch0;
   assign cell_h_1  = sel ? b_ch1  : a_ch1;
   assign out_h_0   = sel ? b_oh0  : a_oh0;
   assign out_h_1   = sel ? b_oh1  : a_oh1;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [W-1:0] xs0 [16];
   logic [W-1:0] xs1 [16];

   // Runs one full sequence on the selected instance; expected hidden states
   // come from h_t = sat(x_t + h_{t-1}), output latency CL+1 after each accept.
   task automatic run_seq(input bit which, input int len, input logic [W-1:0] hi0,
                          input logic [W-1:0] hi1, input int bp);
      int cl, lat;
      logic [W-1:0] m0, m1;
      cl = which ? 3 : 1;
      sel = which;
      start = 1'b1; seq_len = LW'(len); h_init_0 = hi0; h_init_1 = hi1;
      tick();
      start = 1'b0;
      if (len == 0) begin
         chk("zero_len_done", done, 1);
         chk("zero_len_busy", busy, 0);
         chk("zero_len_ready", in_ready, 0);
         tick();
         chk("zero_len_done_clr", done, 0);
         chk("zero_len_ready2", in_ready, 0);
         return;
      end
      m0 = hi0; m1 = hi1;
      for (int t = 0; t < len; t++) begin
         chk("wait_ready", in_ready, 1);
         chk("busy_step", busy, 1);
         in_x_0 = xs0[t]; in_x_1 = xs1[t]; in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         chk("cell_x", cell_x_0, xs0[t]);
         chk("cell_h_prev0", cell_h_0, m0);
         chk("cell_h_prev1", cell_h_1, m1);
         chk("compute_ready", in_ready, 0);
         m0 = sat(xs0[t], m0);
         m1 = sat(xs1[t], m1);
         lat = 0;
         while (!out_valid && lat < 20) begin
            tick();
            lat++;
         end
         chk("out_latency", lat, cl + 1);
         if (!out_valid) return;
         chk("out_h0", out_h_0, m0);
         chk("out_h1", out_h_1, m1);
         chk("out_last", out_last, (t == len - 1) ? 1 : 0);
         for (int k = 0; k < bp; k++) begin
            tick();
            chk("bp_valid", out_valid, 1);
            chk("bp_h0", out_h_0, m0);
            chk("bp_ready", in_ready, 0);
         end
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         chk("out_valid_clr", out_valid, 0);
         if (t == len - 1) begin
            chk("done_pulse", done, 1);
            chk("idle_busy", busy, 0);
            tick();
            chk("done_clr", done, 0);
         end else begin
            chk("no_done", done, 0);
         end
      end
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      sel = 1'b0; seq_len = '0; h_init_0 = '0; h_init_1 = '0; in_x_0 = '0; in_x_1 = '0;
      repeat (2) tick();

      // reset state
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", in_ready, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_last", out_last, 0);
      chk("rst_out_h", out_h_0, 0);
      chk("rst_cell_x", cell_x_0, 0);
      reset_n = 1'b1;
      tick();

      // asynchronous reset in the middle of COMPUTE
      start = 1'b1; seq_len = 8'd1; h_init_0 = 17'h0033; h_init_1 = 17'h0044;
      tick();
      start = 1'b0;
      in_x_0 = 17'h0100; in_x_1 = 17'h0001; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("pre_rst_h", cell_h_0, 17'h0033);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_valid", out_valid, 0);
      chk("arst_ready", in_ready, 0);
      chk("arst_cell_h", cell_h_0, 0);
      chk("arst_cell_x", cell_x_0, 0);
      #2 reset_n = 1'b1;
      tick();
      tick();
      chk("post_rst_busy", busy, 0);
      chk("post_rst_ready", in_ready, 0);
      chk("post_rst_done", done, 0);

      // single step
      xs0[0] = 17'h0100; xs1[0] = 17'h0000;
      run_seq(1'b0, 1, 17'h0000, 17'h0000, 0);

      // three steps, then same with backpressure
      for (int t = 0; t < 3; t++) begin xs0[t] = 17'h0100; xs1[t] = 17'h0000; end
      run_seq(1'b0, 3, 17'h0080, 17'h0000, 0);
      chk("seq3_final", out_h_0, 17'h0380);
      run_seq(1'b0, 3, 17'h0080, 17'h0000, 5);

      // zero length
      run_seq(1'b0, 0, 17'h0011, 17'h0022, 0);

      // start while busy is ignored, abort in COMPUTE
      sel = 1'b0;
      start = 1'b1; seq_len = 8'd2; h_init_0 = 17'h0011; h_init_1 = 17'h0022;
      tick();
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      start = 1'b1; seq_len = 8'd0; h_init_0 = 17'h0007; h_init_1 = 17'h0007;
      tick();
      start = 1'b0;
      chk("restart_h", cell_h_0, 17'h0011);
      chk("restart_busy", busy, 1);
      chk("restart_done", done, 0);
      in_x_0 = 17'h0005; in_x_1 = 17'h0005; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("abort_pre_x", cell_x_0, 17'h0005);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_valid", out_valid, 0);
      chk("abort_h_kept", cell_h_0, 17'h0011);
      tick();
      chk("abort_done2", done, 0);

      // abort together with in_valid in WAIT_X: sample not taken
      start = 1'b1; seq_len = 8'd1; h_init_0 = 17'h0011; h_init_1 = 17'h0022;
      tick();
      start = 1'b0;
      in_x_0 = 17'h0009; in_valid = 1'b1; abort = 1'b1;
      tick();
      in_valid = 1'b0; abort = 1'b0;
      chk("abort_wx_busy", busy, 0);
      chk("abort_wx_x", cell_x_0, 17'h0005);

      // abort and start together in IDLE: start ignored
      start = 1'b1; abort = 1'b1; seq_len = 8'd2;
      tick();
      start = 1'b0; abort = 1'b0;
      chk("abort_start_idle", busy, 0);

      // latency-3 instance
      for (int t = 0; t < 3; t++) begin xs0[t] = 17'h0100; xs1[t] = 17'h0000; end
      run_seq(1'b1, 3, 17'h0080, 17'h0000, 0);
      chk("seq3_cl3_final", out_h_0, 17'h0380);

      // randomized sequences on both instances, including saturating values
      for (int r = 0; r < 10; r++) begin
         int len;
         len = $urandom_range(1, 5);
         for (int t = 0; t < len; t++) begin
            xs0[t] = W'($urandom);
            xs1[t] = W'($urandom);
         end
         run_seq(r[0], len, W'($urandom), W'($urandom), $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/gru_seq_driver.md
Name: gru_seq_driver

Overview:
- Drives the 2-unit fixed-point GRU cell across a time sequence: accepts x_t samples on a valid/ready stream and presents x_t with h_{t-1} to the cell.
- Captures the cell output after the cell latency, feeds it back as the next h, and emits each h_t on a valid/ready output stream.
- Sits between the input sample stream and the cell's x/h/y ports. Weights and biases are wired to the cell directly, not through this block.

Parameters:
- INT_WIDTH, 8, integer bits of the Qm.f datapath.
- FRAC_WIDTH, 8, fractional bits.
- WIDTH, INT_WIDTH+FRAC_WIDTH+1, signed sample width.
- CELL_LATENCY, 1, cycles from stable cell inputs to valid cell_y; must be ≥1.
- LEN_W, 8, width of seq_len and of the step counter.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a sequence; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE with no done pulse.
- seq_len  in  LEN_W  number of timesteps; latched on start.
- h_init_0, h_init_1  in  WIDTH each  initial hidden state; latched on start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a sequence completes.
- in_valid  in  1  input sample valid.
- in_ready  out  1  high only in WAIT_X.
- in_x_0, in_x_1  in  WIDTH each  input sample.
- cell_x_0_0, cell_x_0_1  out  WIDTH each  to cell x ports (x register).
- cell_h_0_0, cell_h_0_1  out  WIDTH each  to cell h ports (h register).
- cell_y_0_0, cell_y_0_1  in  WIDTH each  from cell outputs.
- out_valid  out  1  output hidden state valid.
- out_ready  in  1  downstream ready.
- out_h_0, out_h_1  out  WIDTH each  h_t (the h register).
- out_last  out  1  high with out_valid on the final step.

Behaviour:

Reset
- reset_n low: state=IDLE; x/h registers, step counter and latency counter cleared to 0.
- All outputs 0: busy, done, in_ready, out_valid, out_last, and all data outputs.
- The effect is immediate (asynchronous). A step in flight is discarded.

IDLE
- start=1 latches seq_len into len, h_init into the h register, and clears step to 0.
  - len==0: done=1 next cycle; stay IDLE.
  - Otherwise go to WAIT_X.

WAIT_X
- in_ready=1.
- On in_valid&&in_ready: latch in_x into the x register, clear the latency counter lcnt, go to COMPUTE.

COMPUTE
- Cell inputs are held stable.
- lcnt increments each cycle.
- At the edge where lcnt==CELL_LATENCY: h register <= cell_y; go to OUTPUT.
- out_valid rises CELL_LATENCY+1 cycles after the accepting in_ handshake edge.

OUTPUT
- out_valid=1; out_last=(step==len-1).
- On out_valid&&out_ready:
  - Not last: step++; go to WAIT_X.
  - Last: go to IDLE; done=1 for the following cycle.
- out_valid held high and out_h stable until accepted; in_ready=0 meanwhile.

General rules
- cell_h always reflects the h register and cell_x the x register, in every state. No arithmetic is performed on data; values pass through unmodified.
- Counters: step counts 0..len-1 and never wraps; len=2^LEN_W-1 is the maximum sequence.
- start while busy is ignored.
- abort has priority over all transitions in non-IDLE states: next state IDLE, no done, and the h register keeps its value.
- abort and start together in IDLE: start is ignored.
- Simultaneous in_valid and abort in WAIT_X: the sample is not accepted.
- Throughput: one step per CELL_LATENCY+3 cycles with always-valid/ready streams.

Test Plan:
1. Cell stub y=x+h (saturating), CELL_LATENCY=1; reset_n asserted low mid-COMPUTE -> same cycle: busy=0, out_valid=0, in_ready=0, cell_h=0; after release, state is IDLE.
2. h_init=(0,0), seq_len=1, x=(0x0100,0x0000) -> out_valid exactly 2 cycles after the in_ handshake; out_h=(0x0100,0), out_last=1; done pulses one cycle after the out_ handshake.
3. h_init=(0x0080,0), seq_len=3, x=(0x0100,0) each step -> outputs 0x0180, 0x0280, 0x0380; cell_h_0_0=0x0180 during step 2; out_last only on the third output.
4. Backpressure: out_ready low for 5 cycles in OUTPUT -> out_valid stays 1, out_h unchanged, in_ready 0; completes after out_ready rises.
5. seq_len=0 with start -> done pulse one cycle after start; in_ready never asserted; busy stays 0.
6. start asserted while busy -> ignored. abort during COMPUTE -> IDLE next cycle, no done. Repeat test 3 with CELL_LATENCY=3 -> out_valid 4 cycles after each in_ handshake, same values.
